// File: rtl/des_pkg.sv
// des_pkg: DES block width and the CBC sequencer state encoding,
// shared with the UART command FSM.
package des_pkg;

    localparam int DES_BLK_W = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        START = ST_START,
        WAIT  = ST_WAIT,
        OUT   = ST_OUT,
        FIN   = ST_FIN
    } state_t;

endpackage

// File: rtl/des_cbc_chain.sv
// des_cbc_chain: CBC chaining value, pending ciphertext and the direction-
// dependent XOR muxes around the DES core.
module des_cbc_chain
    import des_pkg::*;
(
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_fDec,
    input  logic                 i_fLoadIv,
    input  logic [DES_BLK_W-1:0] i_IV,
    input  logic                 i_fIn,
    input  logic [DES_BLK_W-1:0] i_InData,
    input  logic                 i_fCore,
    input  logic [DES_BLK_W-1:0] i_CoreData,
    output logic [DES_BLK_W-1:0] o_PreData,
    output logic [DES_BLK_W-1:0] o_PostData
);

    logic [DES_BLK_W-1:0] chain_q, chain_d;
    logic [DES_BLK_W-1:0] pend_q, pend_d;

    // Decrypt chains on the ciphertext that entered the core, hence pend.
    always_comb begin
        o_PreData  = i_fDec ? i_InData : i_InData ^ chain_q;
        o_PostData = i_fDec ? i_CoreData ^ chain_q : i_CoreData;
        chain_d    = i_fLoadIv ? i_IV : i_fCore ? (i_fDec ? pend_q : i_CoreData) : chain_q;
        pend_d     = (i_fIn && i_fDec) ? i_InData : pend_q;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            chain_q <= '0;
            pend_q  <= '0;
        end else begin
            chain_q <= chain_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: runs a single-block DES core over a multi-block CBC message,
// with valid/ready block streams on both host sides and a core watchdog.
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int NUM_BLK_W = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_fStart,
    input  logic                 i_fDec,
    input  logic [DES_BLK_W-1:0] i_Key,
    input  logic [DES_BLK_W-1:0] i_IV,
    input  logic [NUM_BLK_W-1:0] i_BlkCnt,
    input  logic                 i_fInValid,
    input  logic [DES_BLK_W-1:0] i_InData,
    output logic                 o_fInReady,
    output logic                 o_fOutValid,
    output logic [DES_BLK_W-1:0] o_OutData,
    input  logic                 i_fOutReady,
    output logic                 o_DES_fStart,
    output logic                 o_DES_fDec,
    output logic [DES_BLK_W-1:0] o_DES_Key,
    output logic [DES_BLK_W-1:0] o_DES_Text,
    input  logic                 i_DES_fDone,
    input  logic [DES_BLK_W-1:0] i_DES_Data,
    output logic                 o_fBusy,
    output logic                 o_fDone,
    output logic                 o_fErr
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [DES_BLK_W-1:0] key_q, key_d, text_q, text_d, res_q, res_d;
    logic                 dec_q, dec_d, err_q, err_d;
    logic [NUM_BLK_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [DES_BLK_W-1:0] pre, post;
    logic                 start_ok, in_fire, core_fire, wd_exp;

    assign start_ok  = state_q == IDLE && i_fStart;
    assign in_fire   = state_q == LOAD && i_fInValid;
    assign core_fire = state_q == WAIT && i_DES_fDone;
    // wd_q + 1 is the count for the current WAIT cycle.
    assign wd_exp    = wd_q >= WD_LAST;

    des_cbc_chain u_chain (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_fDec     (dec_q),
        .i_fLoadIv  (start_ok),
        .i_IV       (i_IV),
        .i_fIn      (in_fire),
        .i_InData   (i_InData),
        .i_fCore    (core_fire),
        .i_CoreData (i_DES_Data),
        .o_PreData  (pre),
        .o_PostData (post)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        dec_d   = dec_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        text_d  = in_fire ? pre : text_q;
        res_d   = core_fire ? post : res_q;
        wd_d    = state_q == START ? '0 : (state_q == WAIT && wd_q != WD_MAX) ? wd_q + 1'b1 : wd_q;
        case (state_q)
            IDLE: if (i_fStart) begin
                key_d   = i_Key;
                dec_d   = i_fDec;
                cnt_d   = i_BlkCnt;
                err_d   = i_BlkCnt == '0;
                state_d = i_BlkCnt == '0 ? FIN : LOAD;
            end
            LOAD:  state_d = i_fInValid ? START : LOAD;
            START: state_d = WAIT;
            WAIT: if (i_DES_fDone) begin
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                state_d = OUT;
            end else if (wd_exp) begin
                err_d   = 1'b1;
                state_d = FIN;
            end
            OUT:     state_d = i_fOutReady ? (cnt_q == '0 ? FIN : LOAD) : OUT;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wd_q    <= '0;
            text_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            text_q  <= text_d;
            res_q   <= res_d;
        end
    end

    assign o_fInReady   = state_q == LOAD;
    assign o_fOutValid  = state_q == OUT;
    assign o_DES_fStart = state_q == START;
    assign o_fDone      = state_q == FIN;
    assign o_fBusy      = state_q != IDLE;
    assign o_OutData    = res_q;
    assign o_DES_Key    = key_q;
    assign o_DES_fDec   = dec_q;
    assign o_DES_Text   = text_q;
    assign o_fErr       = err_q;

endmodule
